mini_cpu_ctrl: RTL and testbench

Multi-cycle control and execute stage for the mini CPU datapath, sitting directly upstream of the 8-entry register file. It fetches 16-bit instructions over a valid/request handshake and decodes them. It drives the register file's two combinational read ports, computes ALU results, and issues exactly one register-file write per write-type instruction. It owns the program counter and the halt state.

---
 rtl/mini_cpu_pkg.sv | 43 ++++
 rtl/mini_alu.sv | 26 ++
 rtl/mini_cpu_ctrl.sv | 101 ++++++++++
 tb/tb_mini_cpu_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - opcodes, FSM state codes and instruction field positions for mini_cpu_ctrl
package mini_cpu_pkg;

    localparam int INSTR_WIDTH = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOP  = 4'd0;
    localparam opcode_t OP_ADD  = 4'd1;
    localparam opcode_t OP_SUB  = 4'd2;
    localparam opcode_t OP_AND  = 4'd3;
    localparam opcode_t OP_OR   = 4'd4;
    localparam opcode_t OP_XOR  = 4'd5;
    localparam opcode_t OP_LDI  = 4'd6;
    localparam opcode_t OP_BEQZ = 4'd7;
    localparam opcode_t OP_JMP  = 4'd8;
    localparam opcode_t OP_HALT = 4'd15;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_WB     = 3'd3;
    localparam state_t ST_HALT   = 3'd4;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // ALU ops plus LDI are the only instructions that produce a register write
    function automatic logic is_write_op(input opcode_t op);
        return (op >= OP_ADD) && (op <= OP_LDI);
    endfunction

endpackage

// File: rtl/mini_alu.sv
// rtl/mini_alu.sv - combinational ALU for the mini CPU; carries and borrows are dropped
module mini_alu
    import mini_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  opcode_t               i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOP:  o_result = '0;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/mini_cpu_ctrl.sv
// rtl/mini_cpu_ctrl.sv - multi-cycle fetch/decode/execute/write-back controller for the mini CPU
module mini_cpu_ctrl
    import mini_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int PC_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic                         imem_valid,
    input  logic [INSTR_WIDTH-1:0]       imem_instr,
    output logic [$clog2(REG_COUNT)-1:0] rf_read_addr1,
    output logic [$clog2(REG_COUNT)-1:0] rf_read_addr2,
    input  logic [DATA_WIDTH-1:0]        rf_read_data1,
    input  logic [DATA_WIDTH-1:0]        rf_read_data2,
    output logic                         rf_write_en,
    output logic [$clog2(REG_COUNT)-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]        rf_write_data,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted
);

    state_t                   r_state;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [DATA_WIDTH-1:0]    r_wb_data;
    logic                     r_taken;

    opcode_t                  w_op;
    logic [DATA_WIDTH-1:0]    w_alu_result;
    logic [DATA_WIDTH-1:0]    w_imm_data;
    logic [PC_WIDTH-1:0]      w_target;

    assign w_op       = r_instr[OP_MSB:OP_LSB];
    assign w_imm_data = DATA_WIDTH'(r_instr[IMM_MSB:IMM_LSB]);
    assign w_target   = PC_WIDTH'(r_instr[IMM_MSB:IMM_LSB]);

    mini_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_op     (w_op),
        .i_a      (rf_read_data1),
        .i_b      (rf_read_data2),
        .o_result (w_alu_result)
    );

    // Read addresses come straight from the latched instruction, so they stay
    // stable from DECODE through WB without extra registers.
    assign rf_read_addr1 = r_instr[RS1_MSB:RS1_LSB];
    assign rf_read_addr2 = r_instr[RS2_MSB:RS2_LSB];
    assign rf_write_addr = r_instr[RD_MSB:RD_LSB];
    assign rf_write_data = r_wb_data;
    assign rf_write_en   = (r_state == ST_WB) && is_write_op(w_op);

    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign halted    = (r_state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_instr   <= '0;
            r_pc      <= '0;
            r_wb_data <= '0;
            r_taken   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_valid) begin
                        r_instr <= imem_instr;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_wb_data <= (w_op == OP_LDI) ? w_imm_data : w_alu_result;
                    r_taken   <= (w_op == OP_JMP) ||
                                 ((w_op == OP_BEQZ) && (rf_read_data1 == '0));
                    r_state   <= (w_op == OP_HALT) ? ST_HALT : ST_WB;
                end
                ST_WB: begin
                    r_pc    <= r_taken ? w_target : r_pc + PC_WIDTH'(1);
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mini_cpu_ctrl.sv
// tb/tb_mini_cpu_ctrl.sv - directed and randomized self-checking bench for mini_cpu_ctrl
module tb_mini_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_instr;
    logic [2:0]  rf_read_addr1, rf_read_addr2;
    logic [7:0]  rf_read_data1, rf_read_data2;
    logic        rf_write_en;
    logic [2:0]  rf_write_addr;
    logic [7:0]  rf_write_data;
    logic [7:0]  pc;
    logic        halted;

    logic [15:0] imem [256];
    logic [7:0]  rf [8];
    logic [10:0] wlog [$];
    int          log_base = 0;

    int checks = 0;
    int failures = 0;

    // architectural model: registers, pc, and the one instruction in flight
    logic [7:0]  m_rf [8];
    int          m_pc = 0;
    bit          m_busy = 0;
    bit          m_halted = 0;
    int          m_start = 0;
    logic [15:0] m_ins = 16'h0;
    bit          m_wr = 0;
    int          m_wa = 0;
    int          m_wd = 0;
    int          m_npc = 0;
    int          rel = 0;

    always #5 clk = ~clk;

    assign imem_instr    = imem[imem_addr];
    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];

    mini_cpu_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_instr    (imem_instr),
        .rf_read_addr1 (rf_read_addr1),
        .rf_read_addr2 (rf_read_addr2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .pc            (pc),
        .halted        (halted)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 53 + 7) % 256);
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
        return 16'((op << 12) | (rd << 9) | (rs1 << 6) | (rs2 << 3));
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
        return 16'((op << 12) | (rd << 9) | imm);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // register file the DUT writes into
    initial begin
        for (int i = 0; i < 8; i++) rf[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (rf_write_en) begin
                rf[rf_write_addr] <= rf_write_data;
                wlog.push_back({rf_write_addr, rf_write_data});
            end
        end
    end

    task automatic model_step();
        int op, rs1, rs2, imm, a, b;
        if (rst) begin
            m_pc = 0; m_busy = 0; m_halted = 0; rel = 0;
            return;
        end
        rel++;
        if (!m_busy && !m_halted) begin
            if (imem_valid) begin
                m_ins = imem[m_pc];
                op  = int'(m_ins) >> 12;
                m_wa = (int'(m_ins) >> 9) & 7;
                rs1 = (int'(m_ins) >> 6) & 7;
                rs2 = (int'(m_ins) >> 3) & 7;
                imm = int'(m_ins) & 255;
                a = int'(m_rf[rs1]);
                b = int'(m_rf[rs2]);
                m_wr  = (op >= 1 && op <= 6);
                m_npc = (m_pc + 1) % 256;
                case (op)
                    1: m_wd = (a + b) % 256;
                    2: m_wd = (a - b + 256) % 256;
                    3: m_wd = a & b;
                    4: m_wd = a | b;
                    5: m_wd = a ^ b;
                    6: m_wd = imm;
                    7: begin m_wd = 0; if (a == 0) m_npc = imm; end
                    8: begin m_wd = 0; m_npc = imm; end
                    default: m_wd = 0;
                endcase
                m_busy  = 1;
                m_start = rel;
            end
        end else if (m_busy) begin
            if (m_ins[15:12] == 4'hF && rel == m_start + 2) begin
                m_halted = 1;
                m_busy   = 0;
            end else if (rel == m_start + 3) begin
                if (m_wr) m_rf[m_wa] = 8'(m_wd);
                m_pc   = m_npc;
                m_busy = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_rf[i] = init_val(i);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic compare();
        bit exp_we;
        if (rst) begin
            chk("rst_pc", pc, 0);
            chk("rst_halted", halted, 0);
            chk("rst_req", imem_req, 1);
            chk("rst_we", rf_write_en, 0);
            chk("rst_waddr", rf_write_addr, 0);
            chk("rst_wdata", rf_write_data, 0);
            chk("rst_ra1", rf_read_addr1, 0);
            chk("rst_ra2", rf_read_addr2, 0);
        end else begin
            exp_we = m_busy && (rel == m_start + 2) && m_wr;
            chk("pc", pc, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("halted", halted, m_halted);
            chk("imem_req", imem_req, !m_busy && !m_halted);
            chk("we", rf_write_en, exp_we);
            if (exp_we) begin
                chk("waddr", rf_write_addr, m_wa);
                chk("wdata", rf_write_data, m_wd);
            end
            if (m_busy) begin
                chk("ra1", rf_read_addr1, m_ins[8:6]);
                chk("ra2", rf_read_addr2, m_ins[5:3]);
            end
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compare();
        end
    end

    task automatic drive_point();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        drive_point();
        rst = 1'b1;
        drive_point();
        drive_point();
        rst = 1'b0;
        log_base = wlog.size();
    endtask

    task automatic wait_cycle(input int n);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (rel + 1 < n && guard < 2000);
        if (rel + 1 != n) begin
            checks++;
            failures++;
            $display("FAIL wait_cycle actual=%0d required=%0d", rel + 1, n);
        end
    endtask

    task automatic wait_halt(input int bound);
        int g = 0;
        while (halted !== 1'b1 && g < bound) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_timeout actual=%0b required=1", halted);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic load_p1();
        clear_imem();
        imem[0] = enc_i(6, 1, 8'h05);
        imem[1] = enc_i(6, 2, 8'h03);
        imem[2] = enc(1, 3, 1, 2);
        imem[3] = enc(15, 0, 0, 0);
    endtask

    function automatic logic [15:0] rand_instr();
        int op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 7) != 0) op = $urandom_range(1, 6);
        return 16'((op << 12) | $urandom_range(0, 4095));
    endfunction

    initial begin
        clear_imem();
        imem_valid = 1'b1;

        // LDI/LDI/ADD/HALT: halted first seen in cycle 16
        load_p1();
        reset_dut();
        wait_cycle(15);
        chk("t1_not_halted_c15", halted, 0);
        wait_cycle(16);
        chk("t1_halted_c16", halted, 1);
        chk("t1_pc", pc, 8'h03);
        chk("t1_nwrites", wlog.size() - log_base, 3);
        chk("t1_w0", wlog[log_base],     (1 << 8) | 8'h05);
        chk("t1_w1", wlog[log_base + 1], (2 << 8) | 8'h03);
        chk("t1_w2", wlog[log_base + 2], (3 << 8) | 8'h08);
        repeat (8) @(negedge clk);
        chk("t1_no_more_writes", wlog.size() - log_base, 3);

        // SUB wraps to 0xFF, XOR of a register with itself gives 0
        clear_imem();
        imem[0] = enc_i(6, 1, 8'h02);
        imem[1] = enc_i(6, 2, 8'h03);
        imem[2] = enc(2, 4, 1, 2);
        imem[3] = enc(5, 5, 4, 4);
        imem[4] = enc(15, 0, 0, 0);
        reset_dut();
        wait_halt(100);
        chk("t2_nwrites", wlog.size() - log_base, 4);
        chk("t2_sub", wlog[log_base + 2], (4 << 8) | 8'hFF);
        chk("t2_xor", wlog[log_base + 3], (5 << 8) | 8'h00);

        // BEQZ taken on r0==0, then not taken on r1==1 (0x7060 encodes rs1=1)
        clear_imem();
        imem[0]    = enc_i(6, 0, 8'h00);
        imem[1]    = enc_i(6, 1, 8'h01);
        imem[2]    = enc_i(7, 0, 8'h10);
        imem[8'h10] = 16'h7060;
        imem[8'h11] = enc(15, 0, 0, 0);
        reset_dut();
        wait_cycle(13);
        chk("t3_taken_pc", pc, 8'h10);
        wait_halt(100);
        chk("t3_not_taken_pc", pc, 8'h11);
        chk("t3_nwrites", wlog.size() - log_base, 2);

        // three stall cycles in FETCH push the write from cycle 4 to cycle 7
        clear_imem();
        imem[0] = enc_i(6, 6, 8'hA5);
        imem[1] = enc(15, 0, 0, 0);
        imem_valid = 1'b0;
        reset_dut();
        for (int c = 1; c <= 3; c++) begin
            wait_cycle(c);
            chk("t4_stall_req", imem_req, 1);
            chk("t4_stall_pc", pc, 0);
        end
        drive_point();
        imem_valid = 1'b1;
        wait_cycle(6);
        chk("t4_we_c6", rf_write_en, 0);
        wait_cycle(7);
        chk("t4_we_c7", rf_write_en, 1);
        chk("t4_waddr", rf_write_addr, 6);
        chk("t4_wdata", rf_write_data, 8'hA5);

        // JMP 0xFF then NOP at 0xFF wraps pc to 0
        clear_imem();
        imem[0] = enc_i(8, 0, 8'hFF);
        reset_dut();
        wait_cycle(5);
        chk("t5_jmp_pc", pc, 8'hFF);
        wait_cycle(9);
        chk("t5_wrap_pc", pc, 8'h00);

        // reset clears halted, and reset during EXEC of ADD drops its write
        load_p1();
        reset_dut();
        wait_halt(100);
        drive_point();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_halt_cleared", halted, 0);
        drive_point();
        rst = 1'b0;
        log_base = wlog.size();
        wait_cycle(10);
        drive_point();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_we", rf_write_en, 0);
        chk("t6_rst_pc", pc, 0);
        drive_point();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_post_we", rf_write_en, 0);
        chk("t6_post_req", imem_req, 1);
        chk("t6_nwrites", wlog.size() - log_base, 2);

        // random program, random fetch stalls, occasional resets
        for (int i = 0; i < 256; i++) imem[i] = rand_instr();
        for (int c = 0; c < 4000; c++) begin
            drive_point();
            imem_valid = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 119) == 0);
        end
        drive_point();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
